gray_fifo_wr_ctrl: RTL and testbench

GRAY_FIFO_WR_CTRL -- requirements
Module: gray_fifo_wr_ctrl

---
 rtl/gray_fifo_wr_ctrl.sv | 91 +++++++++
 tb/tb_gray_fifo_wr_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gray_fifo_wr_ctrl.sv
// rtl/gray_fifo_wr_ctrl.sv - write-side controller for an async FIFO with Gray-coded pointers
module gray_fifo_wr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 2**ADDR_W - 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENQ,
    input  logic [ADDR_W:0]   RD_PTR_GRAY,
    output logic              WE,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [ADDR_W:0]   WR_PTR_GRAY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic [ADDR_W:0]   COUNT,
    output logic              ERR
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW:0] AF_T = (PW+1)'(AF_THRESH);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [1:0]    ic, ic_nxt;
    logic [PW-1:0] wb, wb_nxt, wg_nxt;
    logic [PW-1:0] s1, s2, rb;
    logic [PW-1:0] cnt_nxt, full_ptr;
    logic          full_nxt, af_nxt;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT;
            ic    <= 2'd0;
        end else begin
            state <= state_nxt;
            ic    <= ic_nxt;
        end
    end

    // Next-state logic: INIT dwells three edges to let the synchronizer settle
    always_comb begin
        state_nxt = state;
        ic_nxt    = ic;
        if (state == INIT) begin
            if (ic == 2'd2) state_nxt = RUN;
            else            ic_nxt    = ic + 2'd1;
        end
    end

    // Output logic
    always_comb begin
        WE = ENQ & ~FULL & ~RST & (state == RUN);
    end

    always_comb begin
        for (int i = 0; i < PW; i++) rb[i] = ^(s2 >> i);
    end

    assign wb_nxt   = WE ? wb + 1'b1 : wb;
    assign wg_nxt   = wb_nxt ^ (wb_nxt >> 1);
    // Full when write pointer is exactly one lap ahead of the synchronized read pointer
    assign full_ptr = {~s2[PW-1:PW-2], s2[PW-3:0]};
    assign cnt_nxt  = wb_nxt - rb;
    assign full_nxt = (state_nxt == INIT) ? 1'b1 : (wg_nxt == full_ptr);
    assign af_nxt   = (state_nxt == RUN) && ({1'b0, cnt_nxt} >= AF_T);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb          <= '0;
            WR_PTR_GRAY <= '0;
            s1          <= '0;
            s2          <= '0;
            COUNT       <= '0;
            FULL        <= 1'b1;
            ALMOST_FULL <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            wb          <= wb_nxt;
            WR_PTR_GRAY <= wg_nxt;
            s1          <= RD_PTR_GRAY;
            s2          <= s1;
            COUNT       <= cnt_nxt;
            FULL        <= full_nxt;
            ALMOST_FULL <= af_nxt;
            if (ENQ && FULL && (state == RUN)) ERR <= 1'b1;
        end
    end

    assign WR_ADDR = wb[ADDR_W-1:0];
endmodule

// File: tb/tb_gray_fifo_wr_ctrl.sv
// tb/tb_gray_fifo_wr_ctrl.sv - directed self-checking bench for gray_fifo_wr_ctrl
module tb_gray_fifo_wr_ctrl;
    localparam int ADDR_W = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ENQ;
    logic [ADDR_W:0]   RD_PTR_GRAY;
    logic              WE;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [ADDR_W:0]   WR_PTR_GRAY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic [ADDR_W:0]   COUNT;
    logic              ERR;

    int errors = 0;
    int checks = 0;

    gray_fifo_wr_ctrl #(.ADDR_W(2), .AF_THRESH(3)) dut (
        .CLK(CLK), .RST(RST), .ENQ(ENQ), .RD_PTR_GRAY(RD_PTR_GRAY),
        .WE(WE), .WR_ADDR(WR_ADDR), .WR_PTR_GRAY(WR_PTR_GRAY),
        .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .COUNT(COUNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [2:0] wb_m, rb_m, prev_g, diff;
    logic       wrapped;

    initial begin
        RST = 1'b1; ENQ = 1'b1; RD_PTR_GRAY = 3'b000;
        tick();
        check("rst_full", FULL, 1);
        check("rst_count", COUNT, 0);
        check("rst_af", ALMOST_FULL, 0);
        check("rst_err", ERR, 0);
        check("rst_gray", WR_PTR_GRAY, 0);
        check("rst_addr", WR_ADDR, 0);
        check("rst_we", WE, 0);
        RST = 1'b0;

        // INIT dwell: FULL held for the reset edge plus two edges
        tick(); check("init1_full", FULL, 1); check("init1_we", WE, 0);
        tick(); check("init2_full", FULL, 1); check("init2_we", WE, 0);
        tick(); check("init3_full", FULL, 0); check("init3_we", WE, 1);

        check("w0_addr", WR_ADDR, 0);
        tick(); check("w0_gray", WR_PTR_GRAY, 3'b001); check("w0_cnt", COUNT, 1); check("w0_af", ALMOST_FULL, 0);
        check("w1_addr", WR_ADDR, 1);
        tick(); check("w1_gray", WR_PTR_GRAY, 3'b011); check("w1_cnt", COUNT, 2); check("w1_af", ALMOST_FULL, 0);
        check("w2_addr", WR_ADDR, 2);
        tick(); check("w2_gray", WR_PTR_GRAY, 3'b010); check("w2_cnt", COUNT, 3); check("w2_af", ALMOST_FULL, 1);
        check("w2_full", FULL, 0);
        check("w3_addr", WR_ADDR, 3);
        tick(); check("w3_gray", WR_PTR_GRAY, 3'b110); check("w3_cnt", COUNT, 4); check("w3_full", FULL, 1);

        // Overflow attempts
        check("ovf_we", WE, 0);
        tick(); check("ovf_err1", ERR, 1); check("ovf_gray1", WR_PTR_GRAY, 3'b110);
        tick(); check("ovf_err2", ERR, 1); check("ovf_gray2", WR_PTR_GRAY, 3'b110); check("ovf_cnt", COUNT, 4);

        // Read pointer advance crosses the synchronizer in two edges
        ENQ = 1'b0; RD_PTR_GRAY = 3'b001;
        tick(); check("rd1_full", FULL, 1);
        tick(); check("rd2_full", FULL, 1);
        tick(); check("rd3_full", FULL, 0); check("rd3_cnt", COUNT, 3); check("rd3_err", ERR, 1);
        ENQ = 1'b1; #1;
        check("refill_we", WE, 1); check("refill_addr", WR_ADDR, 0);
        tick(); check("refill_gray", WR_PTR_GRAY, 3'b111); check("refill_full", FULL, 1); check("refill_cnt", COUNT, 4);
        ENQ = 1'b0;

        // 20 read/write pairs across the pointer wrap
        wb_m = 3'd5; rb_m = 3'd1; wrapped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rb_m = rb_m + 3'd1;
            RD_PTR_GRAY = gray(rb_m);
            tick(); tick(); tick();
            check("pair_cnt_pre", COUNT, 3);
            check("pair_full_pre", FULL, 0);
            ENQ = 1'b1; #1;
            check("pair_we", WE, 1);
            check("pair_addr", WR_ADDR, {1'b0, wb_m[1:0]});
            prev_g = WR_PTR_GRAY;
            tick();
            wb_m = wb_m + 3'd1;
            ENQ = 1'b0;
            diff = prev_g ^ WR_PTR_GRAY;
            if (prev_g == 3'b100 && WR_PTR_GRAY == 3'b000) wrapped = 1'b1;
            check("pair_gray", WR_PTR_GRAY, gray(wb_m));
            check("pair_onebit", 32'(diff[0]) + 32'(diff[1]) + 32'(diff[2]), 1);
            check("pair_cnt_post", COUNT, 4);
            check("pair_full_post", FULL, 1);
        end
        check("wrap_seen", wrapped, 1);

        // Mid-burst reset with COUNT = 2 and ERR set
        rb_m = rb_m + 3'd2;
        RD_PTR_GRAY = gray(rb_m);
        tick(); tick(); tick();
        check("pre_rst_cnt", COUNT, 2);
        check("pre_rst_err", ERR, 1);
        ENQ = 1'b1; RST = 1'b1; RD_PTR_GRAY = 3'b000; #1;
        check("rst_cycle_we", WE, 0);
        tick();
        check("mid_rst_full", FULL, 1);
        check("mid_rst_cnt", COUNT, 0);
        check("mid_rst_af", ALMOST_FULL, 0);
        check("mid_rst_err", ERR, 0);
        check("mid_rst_gray", WR_PTR_GRAY, 0);
        check("mid_rst_addr", WR_ADDR, 0);
        RST = 1'b0;
        tick(); check("re1_we", WE, 0); check("re1_full", FULL, 1);
        tick(); check("re2_we", WE, 0); check("re2_full", FULL, 1);
        tick(); check("re3_we", WE, 1); check("re3_full", FULL, 0);
        tick(); check("re_w_gray", WR_PTR_GRAY, 3'b001); check("re_w_cnt", COUNT, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
